// File: rtl/owt_mcst_frame_rx.sv
// One-wire Manchester frame receiver.
// Oversamples the line, recovers half-bit timing from edges, and decodes:
// sync head, sync tail, command, short/long data, CRC-8 and end tail.
// Each frame ends with a one-cycle o_rx_done pulse and a matching
// o_rx_err code. o_rx_err holds until the next done. Command, data and long
// flag update only on an error-free frame.
module owt_mcst_frame_rx #(
    parameter int               HALF_CYC  = 8,
    parameter int               SYNC_NUM  = 12,
    parameter int               CMD_W     = 8,
    parameter int               DATA_W    = 16,
    parameter int               LDATA_W   = 24,
    parameter logic [CMD_W-2:0] LONG_ADDR = 7'h1f,
    parameter logic [7:0]       CRC_POLY  = 8'h07
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_owt_rx,
    input  logic               i_rx_en,
    output logic               o_busy,
    output logic               o_rx_done,
    output logic [2:0]         o_rx_err,
    output logic               o_rx_long,
    output logic [CMD_W-1:0]   o_rx_cmd,
    output logic [LDATA_W-1:0] o_rx_data,
    output logic [7:0]         o_rx_crc
);

    localparam int PH_W  = $clog2(HALF_CYC);
    localparam int MAX_A = (SYNC_NUM > LDATA_W) ? SYNC_NUM : LDATA_W;
    localparam int MAXN  = (MAX_A > CMD_W) ? MAX_A : CMD_W;
    localparam int CNT_W = $clog2(MAXN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HEAD, S_TAIL, S_CMD, S_DATA, S_LDATA, S_CRC, S_ETAIL, S_DONE
    } state_t;

    // Sampler
    logic [1:0]      sync_q;
    logic            prev_q;
    logic [PH_W-1:0] phase_q;
    logic            lvl, edge_det, strobe;

    // Frame state
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 half_q, half_d;
    logic                 first_q, first_d;
    logic [3:0]           sh4_q, sh4_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [LDATA_W-1:0]   data_q, data_d;
    logic [7:0]           crc_q, crc_d;
    logic [7:0]           rcrc_q, rcrc_d;
    logic                 long_q, long_d;
    logic                 crc_bad_q, crc_bad_d;
    logic [2:0]           err_q, err_d;
    logic [CMD_W-1:0]     ocmd_q, ocmd_d;
    logic [LDATA_W-1:0]   odata_q, odata_d;
    logic                 olong_q, olong_d;
    logic [7:0]           ocrc_q, ocrc_d;

    // Decode helpers
    logic                 pair_valid, viol, cmd_long;
    logic [3:0]           pat;
    logic [CMD_W-1:0]     new_cmd;
    logic [LDATA_W-1:0]   new_data;
    logic [7:0]           new_rcrc;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
    endfunction

    assign lvl        = sync_q[1];
    assign edge_det   = lvl ^ prev_q;
    assign strobe     = (phase_q == PH_W'(HALF_CYC / 2));
    assign pair_valid = strobe & half_q;
    assign viol       = (first_q == lvl);
    assign pat        = {sh4_q[2:0], lvl};
    assign new_cmd    = {cmd_q[CMD_W-2:0], lvl};
    assign new_data   = {data_q[LDATA_W-2:0], lvl};
    assign new_rcrc   = {rcrc_q[6:0], lvl};
    assign cmd_long   = ~new_cmd[CMD_W-1] && (new_cmd[CMD_W-2:0] == LONG_ADDR);

    // Synchronise the line, detect edges and run the half-bit phase counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            sync_q <= {sync_q[0], i_owt_rx};
            prev_q <= sync_q[1];
            if (edge_det || (phase_q == PH_W'(HALF_CYC - 1))) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + PH_W'(1);
            end
        end
    end

    // Frame FSM and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            half_q    <= 1'b0;
            first_q   <= 1'b0;
            sh4_q     <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            crc_q     <= '0;
            rcrc_q    <= '0;
            long_q    <= 1'b0;
            crc_bad_q <= 1'b0;
            err_q     <= '0;
            ocmd_q    <= '0;
            odata_q   <= '0;
            olong_q   <= 1'b0;
            ocrc_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            first_q   <= first_d;
            sh4_q     <= sh4_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            rcrc_q    <= rcrc_d;
            long_q    <= long_d;
            crc_bad_q <= crc_bad_d;
            err_q     <= err_d;
            ocmd_q    <= ocmd_d;
            odata_q   <= odata_d;
            olong_q   <= olong_d;
            ocrc_q    <= ocrc_d;
        end
    end

    // Next-state logic; a violation is tested before any count-complete move
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        first_d   = first_q;
        sh4_d     = sh4_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        crc_d     = crc_q;
        rcrc_d    = rcrc_q;
        long_d    = long_q;
        crc_bad_d = crc_bad_q;
        err_d     = err_q;
        ocmd_d    = ocmd_q;
        odata_d   = odata_q;
        olong_d   = olong_q;
        ocrc_d    = ocrc_q;

        // Pair tracking: first half stored, second half completes a symbol
        if (strobe) begin
            if (half_q) begin
                half_d = 1'b0;
            end else begin
                half_d  = 1'b1;
                first_d = lvl;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                half_d = 1'b0;
                if (strobe) begin
                    first_d = lvl;
                    if (first_q && !lvl) begin
                        state_d = S_HEAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_HEAD: begin
                if (pair_valid) begin
                    if (viol || lvl) begin
                        state_d = S_DONE;
                        err_d   = 3'd1;
                    end else if (cnt_q == CNT_W'(SYNC_NUM - 1)) begin
                        state_d = S_TAIL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_TAIL: begin
                if (strobe) begin
                    sh4_d = pat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(3)) begin
                        if (pat == 4'b1100) begin
                            state_d = S_CMD;
                            cnt_d   = '0;
                            half_d  = 1'b0;
                            cmd_d   = '0;
                            data_d  = '0;
                            crc_d   = 8'h00;
                        end else begin
                            state_d = S_DONE;
                            err_d   = 3'd1;
                        end
                    end
                end
            end
            S_CMD: begin
                if (pair_valid) begin
                    if (viol) begin
                        state_d = S_DONE;
                        err_d   = 3'd2;
                    end else begin
                        cmd_d = new_cmd;
                        crc_d = crc_step(crc_q, lvl);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CMD_W - 1)) begin
                            cnt_d   = '0;
                            long_d  = cmd_long;
                            state_d = cmd_long ? S_LDATA : S_DATA;
                        end
                    end
                end
            end
            S_DATA, S_LDATA: begin
                if (pair_valid) begin
                    if (viol) begin
                        state_d = S_DONE;
                        err_d   = 3'd2;
                    end else begin
                        data_d = new_data;
                        crc_d  = crc_step(crc_q, lvl);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == ((state_q == S_LDATA) ? CNT_W'(LDATA_W - 1)
                                                           : CNT_W'(DATA_W - 1))) begin
                            state_d = S_CRC;
                            cnt_d   = '0;
                            rcrc_d  = 8'h00;
                        end
                    end
                end
            end
            S_CRC: begin
                if (pair_valid) begin
                    if (viol) begin
                        state_d = S_DONE;
                        err_d   = 3'd2;
                    end else begin
                        rcrc_d = new_rcrc;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            crc_bad_d = (new_rcrc != crc_q);
                            ocrc_d    = new_rcrc;
                            state_d   = S_ETAIL;
                            cnt_d     = '0;
                        end
                    end
                end
            end
            S_ETAIL: begin
                if (strobe) begin
                    sh4_d = pat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(3)) begin
                        state_d = S_DONE;
                        if (pat != 4'b1100) begin
                            err_d = 3'd4;
                        end else if (crc_bad_q) begin
                            err_d = 3'd3;
                        end else begin
                            err_d   = 3'd0;
                            ocmd_d  = cmd_q;
                            odata_d = data_q;
                            olong_d = long_q;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                first_d = 1'b0;
                half_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Disabled receiver drops any frame silently; reported values hold
        if (!i_rx_en) begin
            state_d = S_IDLE;
            first_d = 1'b0;
            half_d  = 1'b0;
            err_d   = err_q;
            ocmd_d  = ocmd_q;
            odata_d = odata_q;
            olong_d = olong_q;
            ocrc_d  = ocrc_q;
        end
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_rx_done = (state_q == S_DONE);
    assign o_rx_err  = err_q;
    assign o_rx_long = olong_q;
    assign o_rx_cmd  = ocmd_q;
    assign o_rx_data = odata_q;
    assign o_rx_crc  = ocrc_q;

endmodule

// File: tb/tb_owt_mcst_frame_rx.sv
// Bench for owt_mcst_frame_rx: builds Manchester frames as half-bit lists,
// plays them onto the line, and scores each done pulse against a queue.
module tb_owt_mcst_frame_rx;

    localparam int HALF_CYC = 8;
    localparam int SYNC_NUM = 12;
    localparam int CMD_W    = 8;
    localparam int DATA_W   = 16;
    localparam int LDATA_W  = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        owt_rx;
    logic        rx_en;
    logic        busy;
    logic        rx_done;
    logic [2:0]  rx_err;
    logic        rx_long;
    logic [7:0]  rx_cmd;
    logic [23:0] rx_data;
    logic [7:0]  rx_crc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int prev_d   = 0;
    int mark_idx = -1;
    int mark_cyc = 0;
    int saved_cnt;
    bit prev_done = 1'b0;

    // Expected record: {err[2:0], long, cmd[7:0], data[23:0], crc[7:0]}
    logic [43:0] exp_q[$];
    logic [43:0] e;
    logic        hb[$];

    logic [7:0]  m_cmd  = 8'h00;
    logic [23:0] m_data = 24'h0;
    logic        m_long = 1'b0;
    logic [7:0]  m_crc  = 8'h00;
    logic [7:0]  c1, c2, c3, c4, c5, c6;

    owt_mcst_frame_rx #(
        .HALF_CYC (HALF_CYC),
        .SYNC_NUM (SYNC_NUM),
        .CMD_W    (CMD_W),
        .DATA_W   (DATA_W),
        .LDATA_W  (LDATA_W),
        .LONG_ADDR(7'h1f),
        .CRC_POLY (8'h07)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_owt_rx (owt_rx),
        .i_rx_en  (rx_en),
        .o_busy   (busy),
        .o_rx_done(rx_done),
        .o_rx_err (rx_err),
        .o_rx_long(rx_long),
        .o_rx_cmd (rx_cmd),
        .o_rx_data(rx_data),
        .o_rx_crc (rx_crc)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, required finish before 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [31:0] msg, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic add_manch(input logic b);
        if (b) begin hb.push_back(1'b0); hb.push_back(1'b1); end
        else   begin hb.push_back(1'b1); hb.push_back(1'b0); end
    endtask

    task automatic add_raw4(input logic [3:0] p);
        for (int i = 3; i >= 0; i--) hb.push_back(p[i]);
    endtask

    task automatic build_frame(input logic [7:0] cmd, input logic [23:0] data, input bit lng,
                               input logic [7:0] crc, input logic [3:0] st, input logic [3:0] et);
        int nd;
        hb.delete();
        for (int i = 0; i < SYNC_NUM; i++) add_manch(1'b0);
        add_raw4(st);
        for (int i = 7; i >= 0; i--) add_manch(cmd[i]);
        nd = lng ? LDATA_W : DATA_W;
        for (int i = nd - 1; i >= 0; i--) add_manch(data[i]);
        for (int i = 7; i >= 0; i--) add_manch(crc[i]);
        add_raw4(et);
    endtask

    // Plays half-bits [from, to); jitter moves each boundary by -1..+1 cycle
    task automatic play(input int from, input int to, input bit jit);
        int d;
        int len;
        for (int i = from; i < to; i++) begin
            owt_rx = hb[i];
            if (i == mark_idx) mark_cyc = cyc;
            d = jit ? (int'($urandom_range(2, 0)) - 1) : 0;
            len = HALF_CYC + d - prev_d;
            prev_d = d;
            repeat (len) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        owt_rx = 1'b0;
        prev_d = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [2:0] err, input logic [7:0] cmd, input logic [23:0] data,
                                input bit lng, input bit crc_latched, input logic [7:0] crc);
        if (err == 3'd0) begin
            m_cmd  = cmd;
            m_data = data;
            m_long = lng;
        end
        if (crc_latched) m_crc = crc;
        exp_q.push_back({err, m_long, m_cmd, m_data, m_crc});
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        idle(40);
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, rx_done, 0);
        chk({tag, "_err"},  rx_err, 0);
        chk({tag, "_long"}, rx_long, 0);
        chk({tag, "_cmd"},  rx_cmd, 0);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_crc"},  rx_crc, 0);
    endtask

    // Scoreboard: every done pulse pops one expected record
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", rx_done, 0);
            end
            if (rx_done) begin
                done_cnt++;
                done_cyc = cyc;
                n_chk++;
                assert (exp_q.size() != 0) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL spurious_done: observed done with err %0d, expected no frame", rx_err);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("frame_err",  rx_err,  e[43:41]);
                    chk("frame_long", rx_long, e[40]);
                    chk("frame_cmd",  rx_cmd,  e[39:32]);
                    chk("frame_data", rx_data, e[31:8]);
                    chk("frame_crc",  rx_crc,  e[7:0]);
                end
            end
            prev_done = rx_done;
        end
    end

    // Directed sequence
    initial begin
        rst_n  = 1'b0;
        owt_rx = 1'b0;
        rx_en  = 1'b1;
        repeat (5) @(negedge clk);
        check_clear("reset");
        rst_n = 1'b1;
        idle(40);
        check_clear("post_reset");

        // 1: short write frame
        c1 = crc_of({8'h85, 16'hA5A5}, 24);
        build_frame(8'h85, 24'h00A5A5, 1'b0, c1, 4'b1100, 4'b1100);
        expect_frame(3'd0, 8'h85, 24'h00A5A5, 1'b0, 1'b1, c1);
        play(0, hb.size(), 1'b0);
        wait_drain("t1");

        // 2: long read frame at LONG_ADDR
        c2 = crc_of({8'h1F, 24'h123456}, 32);
        build_frame(8'h1F, 24'h123456, 1'b1, c2, 4'b1100, 4'b1100);
        expect_frame(3'd0, 8'h1F, 24'h123456, 1'b1, 1'b1, c2);
        play(0, hb.size(), 1'b0);
        wait_drain("t2");

        // 2b: write with the long address bits is still a short frame
        c3 = crc_of({8'h9F, 16'hBEEF}, 24);
        build_frame(8'h9F, 24'h00BEEF, 1'b0, c3, 4'b1100, 4'b1100);
        expect_frame(3'd0, 8'h9F, 24'h00BEEF, 1'b0, 1'b1, c3);
        play(0, hb.size(), 1'b0);
        wait_drain("t2b");

        // 3: CRC mismatch keeps cmd/data, latches received CRC
        build_frame(8'h85, 24'h00A5A5, 1'b0, c1 ^ 8'h01, 4'b1100, 4'b1100);
        expect_frame(3'd3, 8'h85, 24'h00A5A5, 1'b0, 1'b1, c1 ^ 8'h01);
        play(0, hb.size(), 1'b0);
        wait_drain("t3");

        // 4: 1,1 pair at data bit 5
        build_frame(8'h85, 24'h00A5A5, 1'b0, c1, 4'b1100, 4'b1100);
        hb[2*SYNC_NUM + 4 + 2*CMD_W + 10] = 1'b1;
        hb[2*SYNC_NUM + 4 + 2*CMD_W + 11] = 1'b1;
        mark_idx = 2*SYNC_NUM + 4 + 2*CMD_W + 11;
        expect_frame(3'd2, 8'h00, 24'h0, 1'b0, 1'b0, 8'h00);
        play(0, mark_idx + 1, 1'b0);
        mark_idx = -1;
        wait_drain("t4");
        chk("viol_done_window",
            ((done_cyc - mark_cyc) >= 1) && ((done_cyc - mark_cyc) <= HALF_CYC + 2), 1);

        // 5a: bad sync tail
        build_frame(8'h85, 24'h00A5A5, 1'b0, c1, 4'b1010, 4'b1100);
        expect_frame(3'd1, 8'h00, 24'h0, 1'b0, 1'b0, 8'h00);
        play(0, 2*SYNC_NUM + 4, 1'b0);
        wait_drain("t5a");

        // 5b: bad end tail, CRC still latched
        c4 = crc_of({8'h3A, 16'h0F0F}, 24);
        build_frame(8'h3A, 24'h000F0F, 1'b0, c4, 4'b1100, 4'b1110);
        expect_frame(3'd4, 8'h00, 24'h0, 1'b0, 1'b1, c4);
        play(0, hb.size(), 1'b0);
        wait_drain("t5b");

        // 6a: jittered edges
        c5 = crc_of({8'hC3, 16'h5A3C}, 24);
        build_frame(8'hC3, 24'h005A3C, 1'b0, c5, 4'b1100, 4'b1100);
        expect_frame(3'd0, 8'hC3, 24'h005A3C, 1'b0, 1'b1, c5);
        play(0, hb.size(), 1'b1);
        wait_drain("t6a");

        // 6b: enable dropped mid-frame
        c6 = crc_of({8'h1F, 24'hABCDEF}, 32);
        build_frame(8'h1F, 24'hABCDEF, 1'b1, c6, 4'b1100, 4'b1100);
        saved_cnt = done_cnt;
        play(0, 70, 1'b0);
        chk("en_busy_before", busy, 1);
        rx_en = 1'b0;
        @(negedge clk);
        chk("en_busy_after", busy, 0);
        play(70, hb.size(), 1'b0);
        idle(100);
        rx_en = 1'b1;
        idle(200);
        chk("en_no_done", done_cnt, saved_cnt);
        chk("en_err_hold", rx_err, 3'd0);
        chk("en_cmd_hold", rx_cmd, 8'hC3);

        // 6c: reset mid-frame
        build_frame(8'h85, 24'h00A5A5, 1'b0, c1, 4'b1100, 4'b1100);
        saved_cnt = done_cnt;
        play(0, 60, 1'b0);
        chk("rst_busy_before", busy, 1);
        rst_n  = 1'b0;
        owt_rx = 1'b0;
        repeat (3) @(negedge clk);
        check_clear("rst_mid");
        rst_n = 1'b1;
        idle(200);
        check_clear("rst_after");
        chk("rst_no_done", done_cnt, saved_cnt);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/owt_mcst_frame_rx.md
Name: owt_mcst_frame_rx

Overview:
- Parametrised one-wire Manchester frame receiver for the LV side; next generation of the fixed-format OWT receive controller.
- Recovers half-bit timing from the oversampled line and decodes sync head, sync tail, command, short or long data, CRC-8 and end tail.
- Reports each frame with a done pulse and an error code.
- Field widths, sync length, long-data command address and CRC polynomial are parameters.

Parameters:
HALF_CYC, 8, clock cycles per Manchester half-bit; even, >=4
SYNC_NUM, 12, number of Manchester-0 symbols in sync head
CMD_W, 8, command bits; MSB=1 write, MSB=0 read
DATA_W, 16, data bits of a normal frame
LDATA_W, 24, data bits of a long frame; LDATA_W>=DATA_W
LONG_ADDR, 7'h1f, CMD_W-1 bit address selecting long data on a read
CRC_POLY, 8'h07, CRC-8 polynomial (init 8'h00)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_owt_rx  in  1  raw one-wire line (asynchronous)
i_rx_en  in  1  receiver enable
o_busy  out  1  FSM not in IDLE
o_rx_done  out  1  one-cycle frame-end pulse
o_rx_err  out  3  0 ok, 1 sync, 2 Manchester violation, 3 CRC mismatch, 4 end-tail
o_rx_long  out  1  last good frame was long
o_rx_cmd  out  CMD_W  last good command
o_rx_data  out  LDATA_W  last good data, zero-extended for normal frames
o_rx_crc  out  8  received CRC of last completed frame

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All outputs 0, FSM in IDLE, sampler counters 0. Reset mid-frame discards the frame with no done pulse.
- Input: 2-flop synchroniser, then edge detect on the synced level.
- Phase counter: cleared on every edge; otherwise wraps at HALF_CYC-1.
- Half-bit strobe fires when the phase counter equals HALF_CYC/2. Sample = synced level at that cycle.
- Manchester symbol = two consecutive half-bit samples: 1,0 = bit 0; 0,1 = bit 1; equal = violation.
- IDLE: waits for a sample of 1.
  - Next sample 0 = first head zero; pair phase is locked; go to HEAD with count 1.
  - Any other result stays in IDLE silently.
- HEAD: count Manchester zeros until count==SYNC_NUM, then go to TAIL. A one or a violation gives err 1.
- TAIL: shift 4 raw half-bits. Pattern 4'b1100 goes to CMD; any other pattern gives err 1.
- CMD: shift CMD_W bits, MSB first.
  - cmd[CMD_W-1]==0 and cmd[CMD_W-2:0]==LONG_ADDR: go to LDATA (LDATA_W bits).
  - Otherwise: go to DATA (DATA_W bits).
- DATA/LDATA: shift bits MSB first, then go to CRC (8 bits).
- CRC computation: serial, MSB-first, over all cmd+data bits.
  - crc <= {crc[6:0],0} ^ (crc[7]^bit ? CRC_POLY : 0).
  - Reset to 0 on the first CMD bit.
- CRC state: after 8 received bits, go to ETAIL. Latch received CRC to o_rx_crc. A mismatch is recorded but does not abort.
- ETAIL: shift 4 raw half-bits.
  - Expected pattern is 4'b1100. Mismatch gives err 4; otherwise a recorded CRC mismatch gives err 3; else err 0.
  - The frame ends on the 4th half-bit strobe.
- Violation in CMD/DATA/LDATA/CRC: err 2, immediate end.
- Termination (error or end): next cycle o_rx_done=1 for exactly one cycle, with o_rx_err valid the same cycle; FSM returns to IDLE.
- Outputs on a good frame: o_rx_cmd, o_rx_data and o_rx_long update only when err==0, in the same cycle as o_rx_done. On error they hold previous values.
- Latency: o_rx_done asserts 1 cycle after the terminating strobe.
- o_rx_err holds until the next done.
- Priority within a cycle: a violation is checked before the count-complete transition.
- i_rx_en low: FSM forced to IDLE next cycle with no done pulse. The sampler keeps running.
- A done pulse and a new IDLE detection cannot overlap: the IDLE search starts the cycle after done.
- The sampler does not track line idling; an idle low line yields 0 samples and stays in IDLE.

Test Plan:
1. Write frame cmd 8'h85, data 16'hA5A5, correct CRC, tails 1100 -> one done pulse, err 0, o_rx_cmd 8'h85, o_rx_data 24'h00A5A5, o_rx_long 0.
2. Read frame cmd 8'h1F, data 24'h123456, correct CRC -> done, err 0, o_rx_long 1, o_rx_data 24'h123456.
3. Frame from test 1 with CRC LSB flipped -> err 3, o_rx_crc = flipped value, cmd/data hold previous values.
4. Half-bit pair 1,1 injected at data bit 5 -> done 1 cycle after that strobe, err 2, o_busy low next cycle.
5. Sync tail 1010, then end tail 1110 in a separate frame -> err 1, then err 4.
6. Edge jitter of ±1 cycle on every transition with HALF_CYC=8, plus i_rx_en dropped and i_rst_n asserted mid-frame -> jittered frame decodes err 0; dropped-enable and reset frames give no done pulse, and reset clears all outputs to 0.
